// File: rtl/mem_stage_pkg.sv
// Shared processor package for the memory stage.
// Holds the FSM state encoding, exception codes, bus payload structs and
// a small alignment helper.
package mem_stage_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned EXC_W  = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam logic [EXC_W-1:0] EXC_NONE     = 2'b00;
  localparam logic [EXC_W-1:0] EXC_MISALIGN = 2'b01;
  localparam logic [EXC_W-1:0] EXC_TIMEOUT  = 2'b10;

  // Writeback bundle presented to the next stage.
  typedef struct packed {
    logic [XLEN-1:0]   data;
    logic [REG_AW-1:0] rd;
    logic              reg_write;
    logic              exc;
    logic [EXC_W-1:0]  exc_code;
  } wb_bundle_t;

  // Command held on the data-memory bus while a request is outstanding.
  typedef struct packed {
    logic            we;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
  } dmem_cmd_t;

  // Word accesses must have the two low address bits clear.
  function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory bus between the memory stage (master) and the memory (slave).
//   dmem_req/dmem_we/dmem_addr/dmem_wdata : request command from master
//   dmem_gnt    : request accepted
//   dmem_rvalid : read data valid, dmem_rdata : read data
interface mem_stage_if;
  import mem_stage_pkg::*;

  logic            dmem_req;
  logic            dmem_we;
  logic [XLEN-1:0] dmem_addr;
  logic [XLEN-1:0] dmem_wdata;
  logic            dmem_gnt;
  logic            dmem_rvalid;
  logic [XLEN-1:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_gnt, dmem_rvalid, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_gnt, dmem_rvalid, dmem_rdata
  );

endinterface

// File: rtl/mem_stage.sv
// Pipeline memory stage: accepts an execute result, performs an optional
// load/store on the data-memory bus with alignment and timeout checking,
// and presents a writeback bundle.
//   clk, rst_n               : clock, async active-low reset
//   in_valid/in_ready        : execute-stage handshake
//   alu_result, reg_data2    : address / ALU data, store data
//   mem_read, mem_write, reg_write, rd : operation controls
//   dmem                     : data-memory bus (master side)
//   out_valid/out_ready      : writeback handshake
//   wb_data, wb_rd, wb_reg_write, exc, exc_code : writeback bundle
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter bit          CHECK_ALIGN    = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   alu_result,
  input  logic [XLEN-1:0]   reg_data2,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              reg_write,
  input  logic [REG_AW-1:0] rd,
  mem_stage_if.master       dmem,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   wb_data,
  output logic [REG_AW-1:0] wb_rd,
  output logic              wb_reg_write,
  output logic              exc,
  output logic [EXC_W-1:0]  exc_code
);

  localparam int unsigned    CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  // Last count value before the wait would reach TIMEOUT_CYCLES cycles.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           r_state,     w_state_nxt;
  logic [CNT_W-1:0] r_cnt,       w_cnt_nxt;
  dmem_cmd_t        r_cmd,       w_cmd_nxt;
  wb_bundle_t       r_wb,        w_wb_nxt;
  logic             r_is_load,   w_is_load_nxt;
  logic             r_dmem_req,  w_dmem_req_nxt;
  logic             r_in_ready,  w_in_ready_nxt;
  logic             r_out_valid, w_out_valid_nxt;

  logic w_is_mem;
  logic w_is_store;

  assign w_is_mem   = mem_read | mem_write;
  // Read wins when both controls are set.
  assign w_is_store = mem_write & ~mem_read;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_cmd       <= '0;
      r_wb        <= '0;
      r_is_load   <= 1'b0;
      r_dmem_req  <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_cmd       <= w_cmd_nxt;
      r_wb        <= w_wb_nxt;
      r_is_load   <= w_is_load_nxt;
      r_dmem_req  <= w_dmem_req_nxt;
      r_in_ready  <= w_in_ready_nxt;
      r_out_valid <= w_out_valid_nxt;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_cmd_nxt     = r_cmd;
    w_wb_nxt      = r_wb;
    w_is_load_nxt = r_is_load;

    unique case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_wb_nxt.data      = alu_result;
          w_wb_nxt.rd        = rd;
          w_wb_nxt.reg_write = reg_write & (rd != '0) & ~w_is_store;
          w_wb_nxt.exc       = 1'b0;
          w_wb_nxt.exc_code  = EXC_NONE;
          if (!w_is_mem) begin
            w_state_nxt = RESP;
          end else if (CHECK_ALIGN && is_misaligned(alu_result)) begin
            w_state_nxt        = RESP;
            w_wb_nxt.reg_write = 1'b0;
            w_wb_nxt.exc       = 1'b1;
            w_wb_nxt.exc_code  = EXC_MISALIGN;
          end else begin
            w_state_nxt     = REQ;
            w_cnt_nxt       = '0;
            w_cmd_nxt.we    = w_is_store;
            w_cmd_nxt.addr  = alu_result;
            w_cmd_nxt.wdata = reg_data2;
            w_is_load_nxt   = mem_read;
          end
        end
      end

      REQ: begin
        // A grant in the final counted cycle still wins over the timeout.
        if (dmem.dmem_gnt) begin
          w_cmd_nxt.we = 1'b0;
          w_cnt_nxt    = '0;
          w_state_nxt  = r_is_load ? WAIT : RESP;
        end else if (r_cnt == CNT_LAST) begin
          w_cmd_nxt.we       = 1'b0;
          w_state_nxt        = RESP;
          w_wb_nxt.reg_write = 1'b0;
          w_wb_nxt.exc       = 1'b1;
          w_wb_nxt.exc_code  = EXC_TIMEOUT;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end

      WAIT: begin
        if (dmem.dmem_rvalid) begin
          w_wb_nxt.data = dmem.dmem_rdata;
          w_state_nxt   = RESP;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt        = RESP;
          w_wb_nxt.reg_write = 1'b0;
          w_wb_nxt.exc       = 1'b1;
          w_wb_nxt.exc_code  = EXC_TIMEOUT;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end

      RESP: begin
        if (out_ready) begin
          w_state_nxt = IDLE;
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    // Handshake flags are registered decodes of the next state.
    w_in_ready_nxt  = (w_state_nxt == IDLE);
    w_out_valid_nxt = (w_state_nxt == RESP);
    w_dmem_req_nxt  = (w_state_nxt == REQ);
  end

  assign in_ready        = r_in_ready;
  assign out_valid       = r_out_valid;
  assign dmem.dmem_req   = r_dmem_req;
  assign dmem.dmem_we    = r_cmd.we;
  assign dmem.dmem_addr  = r_cmd.addr;
  assign dmem.dmem_wdata = r_cmd.wdata;
  assign wb_data         = r_wb.data;
  assign wb_rd           = r_wb.rd;
  assign wb_reg_write    = r_wb.reg_write;
  assign exc             = r_wb.exc;
  assign exc_code        = r_wb.exc_code;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed stimulus pushes expected
// writeback bundles into a queue; a monitor pops and compares on every
// writeback handshake. Bus-side and reset behaviour is checked inline.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] alu_result = '0;
  logic [31:0] reg_data2 = '0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic        reg_write = 1'b0;
  logic [4:0]  rd = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        wb_reg_write;
  logic        exc;
  logic [1:0]  exc_code;

  mem_stage_if bus();

  mem_stage #(.TIMEOUT_CYCLES(4), .CHECK_ALIGN(1'b1)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .alu_result   (alu_result),
    .reg_data2    (reg_data2),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .reg_write    (reg_write),
    .rd           (rd),
    .dmem         (bus),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .wb_data      (wb_data),
    .wb_rd        (wb_rd),
    .wb_reg_write (wb_reg_write),
    .exc          (exc),
    .exc_code     (exc_code)
  );

  always #5 clk = ~clk;

  int         n_vec = 0;
  int         n_err = 0;
  wb_bundle_t exp_q[$];
  wb_bundle_t mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic wb_bundle_t mk(input logic [31:0] d, input logic [4:0] r,
                                    input logic rw, input logic e, input logic [1:0] c);
    wb_bundle_t b;
    b.data = d; b.rd = r; b.reg_write = rw; b.exc = e; b.exc_code = c;
    return b;
  endfunction

  // Scoreboard monitor: compare every accepted writeback bundle.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_wb: got data 0x%08h rd %0d with empty queue", wb_data, wb_rd);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wb_data",      wb_data,              mon_e.data);
        chk("wb_rd",        32'(wb_rd),           32'(mon_e.rd));
        chk("wb_reg_write", 32'(wb_reg_write),    32'(mon_e.reg_write));
        chk("exc",          32'(exc),             32'(mon_e.exc));
        chk("exc_code",     32'(exc_code),        32'(mon_e.exc_code));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one operation and return just after the transfer edge.
  task automatic issue(input logic [31:0] a, input logic [31:0] d2, input logic mr,
                       input logic mw, input logic rw, input logic [4:0] r);
    int n = 0;
    while (!in_ready && n < 20) begin
      step();
      n++;
    end
    if (!in_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL in_ready_wait: got 0 expected 1 within 20 cycles");
    end
    in_valid = 1'b1; alu_result = a; reg_data2 = d2;
    mem_read = mr; mem_write = mw; reg_write = rw; rd = r;
    step();
    in_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; reg_write = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"},   32'(in_ready),       32'd1);
    chk({tag, "_dmem_req"},   32'(bus.dmem_req),   32'd0);
    chk({tag, "_dmem_we"},    32'(bus.dmem_we),    32'd0);
    chk({tag, "_dmem_addr"},  bus.dmem_addr,       32'd0);
    chk({tag, "_dmem_wdata"}, bus.dmem_wdata,      32'd0);
    chk({tag, "_out_valid"},  32'(out_valid),      32'd0);
    chk({tag, "_wb_data"},    wb_data,             32'd0);
    chk({tag, "_wb_rd"},      32'(wb_rd),          32'd0);
    chk({tag, "_wb_rw"},      32'(wb_reg_write),   32'd0);
    chk({tag, "_exc"},        32'(exc),            32'd0);
    chk({tag, "_exc_code"},   32'(exc_code),       32'd0);
  endtask

  initial begin
    int req_cycles;
    bus.dmem_gnt = 1'b0; bus.dmem_rvalid = 1'b0; bus.dmem_rdata = '0;

    // Power-on reset.
    repeat (2) step();
    chk_reset_vals("por");
    rst_n = 1'b1;
    step();
    chk_reset_vals("post_por");

    // ALU op: one-cycle latency, then back in IDLE.
    exp_q.push_back(mk(32'h0000_1234, 5'd5, 1'b1, 1'b0, EXC_NONE));
    issue(32'h0000_1234, 32'h0, 1'b0, 1'b0, 1'b1, 5'd5);
    chk("alu_out_valid", 32'(out_valid), 32'd1);
    chk("alu_in_ready_resp", 32'(in_ready), 32'd0);
    step();
    chk("alu_in_ready_idle", 32'(in_ready), 32'd1);

    // Back-to-back ALU op with rd=0 suppresses the write.
    exp_q.push_back(mk(32'h0000_0055, 5'd0, 1'b0, 1'b0, EXC_NONE));
    issue(32'h0000_0055, 32'h0, 1'b0, 1'b0, 1'b1, 5'd0);
    step();

    // Writeback stall: bundle held while out_ready is low.
    exp_q.push_back(mk(32'hA5A5_0001, 5'd9, 1'b1, 1'b0, EXC_NONE));
    out_ready = 1'b0;
    issue(32'hA5A5_0001, 32'h0, 1'b0, 1'b0, 1'b1, 5'd9);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_out_valid", 32'(out_valid), 32'd1);
      chk("stall_wb_data", wb_data, 32'hA5A5_0001);
    end
    out_ready = 1'b1;
    step();

    // Load at 0x100: grant on the third REQ cycle, rvalid three cycles later.
    exp_q.push_back(mk(32'hDEAD_BEEF, 5'd7, 1'b1, 1'b0, EXC_NONE));
    issue(32'h0000_0100, 32'h0, 1'b1, 1'b0, 1'b1, 5'd7);
    chk("ld_req", 32'(bus.dmem_req), 32'd1);
    chk("ld_we", 32'(bus.dmem_we), 32'd0);
    chk("ld_addr0", bus.dmem_addr, 32'h0000_0100);
    bus.dmem_rvalid = 1'b1; bus.dmem_rdata = 32'h1111_1111;
    step();
    bus.dmem_rvalid = 1'b0; bus.dmem_rdata = '0;
    chk("ld_req1", 32'(bus.dmem_req), 32'd1);
    chk("ld_addr1", bus.dmem_addr, 32'h0000_0100);
    step();
    chk("ld_req2", 32'(bus.dmem_req), 32'd1);
    chk("ld_addr2", bus.dmem_addr, 32'h0000_0100);
    bus.dmem_gnt = 1'b1;
    step();
    bus.dmem_gnt = 1'b0;
    chk("ld_req_drop", 32'(bus.dmem_req), 32'd0);
    step();
    step();
    bus.dmem_rvalid = 1'b1; bus.dmem_rdata = 32'hDEAD_BEEF;
    step();
    bus.dmem_rvalid = 1'b0; bus.dmem_rdata = '0;
    chk("ld_out_valid", 32'(out_valid), 32'd1);
    step();

    // Store at 0x200 with immediate grant.
    exp_q.push_back(mk(32'h0000_0200, 5'd3, 1'b0, 1'b0, EXC_NONE));
    issue(32'h0000_0200, 32'hCAFE_F00D, 1'b0, 1'b1, 1'b1, 5'd3);
    chk("st_req", 32'(bus.dmem_req), 32'd1);
    chk("st_we", 32'(bus.dmem_we), 32'd1);
    chk("st_wdata", bus.dmem_wdata, 32'hCAFE_F00D);
    chk("st_addr", bus.dmem_addr, 32'h0000_0200);
    bus.dmem_gnt = 1'b1;
    step();
    bus.dmem_gnt = 1'b0;
    chk("st_req_drop", 32'(bus.dmem_req), 32'd0);
    chk("st_we_drop", 32'(bus.dmem_we), 32'd0);
    chk("st_out_valid", 32'(out_valid), 32'd1);
    step();

    // Misaligned load: trapped without a bus request.
    exp_q.push_back(mk(32'h0000_0102, 5'd4, 1'b0, 1'b1, EXC_MISALIGN));
    issue(32'h0000_0102, 32'h0, 1'b1, 1'b0, 1'b1, 5'd4);
    chk("mis_req", 32'(bus.dmem_req), 32'd0);
    chk("mis_out_valid", 32'(out_valid), 32'd1);
    step();

    // Read and write both set: behaves as a load.
    exp_q.push_back(mk(32'h0BAD_F00D, 5'd6, 1'b1, 1'b0, EXC_NONE));
    issue(32'h0000_0140, 32'h0000_5555, 1'b1, 1'b1, 1'b1, 5'd6);
    chk("rw_req", 32'(bus.dmem_req), 32'd1);
    chk("rw_we", 32'(bus.dmem_we), 32'd0);
    bus.dmem_gnt = 1'b1;
    step();
    bus.dmem_gnt = 1'b0;
    chk("rw_wait_out_valid", 32'(out_valid), 32'd0);
    bus.dmem_rvalid = 1'b1; bus.dmem_rdata = 32'h0BAD_F00D;
    step();
    bus.dmem_rvalid = 1'b0; bus.dmem_rdata = '0;
    step();

    // Grant never arrives: timeout after four REQ cycles.
    exp_q.push_back(mk(32'h0000_0300, 5'd8, 1'b0, 1'b1, EXC_TIMEOUT));
    issue(32'h0000_0300, 32'h0, 1'b1, 1'b0, 1'b1, 5'd8);
    req_cycles = 0;
    while (bus.dmem_req && req_cycles < 10) begin
      req_cycles++;
      step();
    end
    chk("to_req_cycles", 32'(req_cycles), 32'd4);
    chk("to_out_valid", 32'(out_valid), 32'd1);
    step();

    // Grant in the fourth REQ cycle wins over the timeout.
    exp_q.push_back(mk(32'h0000_0304, 5'd2, 1'b0, 1'b0, EXC_NONE));
    issue(32'h0000_0304, 32'h0000_0077, 1'b0, 1'b1, 1'b1, 5'd2);
    repeat (3) step();
    chk("late_gnt_req", 32'(bus.dmem_req), 32'd1);
    bus.dmem_gnt = 1'b1;
    step();
    bus.dmem_gnt = 1'b0;
    chk("late_gnt_out_valid", 32'(out_valid), 32'd1);
    step();

    // Read data never arrives: timeout after four WAIT cycles.
    exp_q.push_back(mk(32'h0000_0400, 5'd1, 1'b0, 1'b1, EXC_TIMEOUT));
    issue(32'h0000_0400, 32'h0, 1'b1, 1'b0, 1'b1, 5'd1);
    bus.dmem_gnt = 1'b1;
    step();
    bus.dmem_gnt = 1'b0;
    repeat (3) step();
    chk("wto_pending", 32'(out_valid), 32'd0);
    step();
    chk("wto_out_valid", 32'(out_valid), 32'd1);
    step();

    // Reset during REQ drops the request without a clock edge.
    issue(32'h0000_0500, 32'h0000_0099, 1'b0, 1'b1, 1'b1, 5'd10);
    chk("rst_req_before", 32'(bus.dmem_req), 32'd1);
    #1 rst_n = 1'b0;
    #1 chk("rst_req_async", 32'(bus.dmem_req), 32'd0);
    chk_reset_vals("rst_req");
    step();
    rst_n = 1'b1;
    step();

    // Reset during WAIT; a late rvalid after release is ignored.
    issue(32'h0000_0600, 32'h0, 1'b1, 1'b0, 1'b1, 5'd11);
    bus.dmem_gnt = 1'b1;
    step();
    bus.dmem_gnt = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    bus.dmem_rvalid = 1'b1; bus.dmem_rdata = 32'h1234_5678;
    step();
    bus.dmem_rvalid = 1'b0; bus.dmem_rdata = '0;
    for (int i = 0; i < 3; i++) begin
      chk("rst_wait_out_valid", 32'(out_valid), 32'd0);
      step();
    end
    chk_reset_vals("rst_wait");

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: maximum cycles to wait for grant or read data before a bus error.
REQ-002 Parameter CHECK_ALIGN, default 1: when 1, misaligned word accesses are trapped.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  execute-stage result valid.
REQ-006 in_ready  output  1  stage can accept a new operation.
REQ-007 alu_result  input  32  ALU output; memory address for loads/stores, writeback data otherwise.
REQ-008 reg_data2  input  32  store data.
REQ-009 mem_read, mem_write, reg_write  input  1 each  operation controls.
REQ-010 rd  input  5  destination register.
REQ-011 dmem_req  output  1  memory request.
REQ-012 dmem_we  output  1  1 = store.
REQ-013 dmem_addr, dmem_wdata  output  32 each  word address and store data.
REQ-014 dmem_gnt  input  1  request accepted.
REQ-015 dmem_rvalid  input  1  read data valid.
REQ-016 dmem_rdata  input  32  read data.
REQ-017 out_valid  output  1  writeback bundle valid.
REQ-018 out_ready  input  1  writeback accepts bundle.
REQ-019 wb_data  output  32  load data or passed-through alu_result.
REQ-020 wb_rd  output  5; wb_reg_write  output  1  writeback target and enable.
REQ-021 exc  output  1; exc_code  output  2  exception flag and code: 01 misaligned, 10 bus timeout.

Function
REQ-022 FSM states IDLE, REQ, WAIT, RESP.
REQ-023 in_ready SHALL be 1 only in IDLE; transfer occurs on in_valid & in_ready.
REQ-024 Transfer with mem_read=0 and mem_write=0: IDLE -> RESP next cycle; wb_data = alu_result; one-cycle latency.
REQ-025 Transfer with mem_read and mem_write both 1: treated as load, store ignored.
REQ-026 Memory transfer with CHECK_ALIGN=1 and alu_result[1:0] != 0: IDLE -> RESP, exc=1, exc_code=01, wb_reg_write=0, no dmem_req issued.
REQ-027 Aligned memory transfer: IDLE -> REQ; dmem_addr, dmem_wdata, dmem_we registered and held stable while dmem_req=1.
REQ-028 REQ: dmem_req=1 until dmem_gnt; on grant a store goes to RESP, a load goes to WAIT; dmem_req deasserts the cycle after grant.
REQ-029 WAIT: on dmem_rvalid capture dmem_rdata into wb_data, go to RESP; dmem_rvalid outside WAIT is ignored.
REQ-030 A timeout counter clears on entry to REQ and WAIT and increments each cycle in them; reaching TIMEOUT_CYCLES -> RESP with exc=1, exc_code=10, wb_reg_write=0, dmem_req dropped.
REQ-031 Grant or rvalid arriving in the same cycle the counter reaches TIMEOUT_CYCLES SHALL win; no exception is raised.
REQ-032 Stores SHALL force wb_reg_write=0; loads and ALU ops pass reg_write through; rd=0 forces wb_reg_write=0.
REQ-033 RESP: out_valid=1 with wb_* and exc stable until out_ready; on out_valid & out_ready go to IDLE.
REQ-034 Back-to-back throughput for ALU ops SHALL be one operation per two cycles (IDLE, RESP).

Reset
REQ-035 On rst_n low: state IDLE; in_ready=1 after release; dmem_req, dmem_we, out_valid, wb_reg_write, exc = 0; exc_code=00; dmem_addr, dmem_wdata, wb_data = 0; wb_rd=0; timeout counter 0.
REQ-036 Reset asserted mid-transaction SHALL abandon it immediately; dmem_req drops asynchronously and no late rvalid is captured after release.

Structure
REQ-037 State encoding and exc_code constants (EXC_NONE, EXC_MISALIGN, EXC_TIMEOUT) SHALL live in the shared processor package.
REQ-038 No sub-module; the timeout counter is inline, width $clog2(TIMEOUT_CYCLES+1).

Verification
REQ-039 ALU op alu_result=0x0000_1234, rd=5, reg_write=1, out_ready=1 -> out_valid one cycle later, wb_data=0x1234, wb_rd=5, wb_reg_write=1.
REQ-040 Load at 0x100, gnt after 2 cycles, rvalid with 0xDEAD_BEEF 3 cycles later -> wb_data=0xDEADBEEF, exc=0; dmem_addr stable throughout REQ.
REQ-041 Store at 0x200, data 0xCAFE_F00D, immediate gnt -> dmem_we=1, dmem_wdata=0xCAFEF00D for one cycle, wb_reg_write=0.
REQ-042 Load at 0x102 -> no dmem_req, exc=1, exc_code=01.
REQ-043 TIMEOUT_CYCLES=4, gnt never asserted -> exc_code=10 after 4 REQ cycles; repeat with gnt in the 4th cycle -> no exception.
REQ-044 Reset asserted while in WAIT, then rvalid pulsed after release -> outputs at reset values, out_valid stays 0.
